dual_issue_scheduler: RTL
=========================

// Module: dual_issue_scheduler
// PURPOSE
//  Issue controller for the dual-issue SPU core. Accepts one decoded instruction pair per handshake
//  and steers each slot to the even or odd pipe. Holds a per-register busy scoreboard, blocks RAW and
//  WAW hazards, splits a pair that cannot co-issue, and discards pending work on a taken branch.
//  Sits between decode and the register-file/forward/pipe stages.
// PARAMETERS
//  NREG     128  architectural registers (address width 7)
//  MAXLAT   7    longest pipe latency to write-back, in cycles (busy counter width 3)
// PORTS
//  clock        in   1   core clock, rising edge
//  reset        in   1   asynchronous, active-high
//  pair_valid   in   1   decode presents a pair on i0_*/i1_* (i0 is older)
//  pair_ready   out  1   pair is fully issued this cycle; decode advances on valid&&ready
//  iN_pipe      in   1   per slot N=0,1: 0 = even pipe, 1 = odd pipe
//  iN_ra/rb/rc  in   7   per slot: source register addresses
//  iN_src_en    in   3   per slot: {ra,rb,rc} source-used flags
//  iN_rt        in   7   per slot: destination register address
//  iN_wr        in   1   per slot: writes rt
//  iN_lat       in   3   per slot: result latency 1..MAXLAT; 0 is illegal
//  flush        in   1   branch taken in odd pipe; kill unissued work
//  ep_issue     out  1   registered: even pipe receives an instruction
//  ep_slot      out  1   registered: slot (0/1) sent to even pipe
//  op_issue     out  1   registered: odd pipe receives an instruction
//  op_slot      out  1   registered: slot sent to odd pipe
//  stall_cnt    out  16  saturating count of cycles pair_valid=1 with nothing issued
// BEHAVIOUR
//  Reset (async): state=FULL, all busy[r]=0, ep_issue=op_issue=ep_slot=op_slot=0, stall_cnt=0;
//   pair_ready forced 0 while reset is high.
//  Scoreboard: busy[r] counts cycles until r is forwardable. Each edge every nonzero entry decrements,
//   then an issuing writer loads busy[rt]<=lat. Both slots can load in one edge (distinct rt, guaranteed).
//  Hazard for slot s: RAW = some enabled source r has busy[r]!=0;
//   WAW = wr && busy[rt] > lat (completes before an older writer).
//  States: FULL (neither slot issued), HALF (i0 issued, i1 pending).
//  FULL, pair_valid=1:
//   - i0 issues if it is hazard-free; else nothing issues and state stays FULL.
//   - i1 co-issues iff i0 issues, i1_pipe!=i0_pipe, i1 hazard-free, no enabled i1 source equals
//     i0_rt when i0_wr, and !(i0_wr&&i1_wr&&i0_rt==i1_rt).
//   - both issue -> pair_ready=1, stay FULL. Only i0 issues -> pair_ready=0, next state HALF.
//  HALF: i1 evaluated alone (pipe free, hazard-free) -> issues, pair_ready=1, next FULL; else hold.
//  Decision is combinational in cycle t; ep_*/op_* registered, visible in cycle t+1 (latency 1);
//   the scoreboard updates at the same edge.
//  A non-issue cycle registers ep_issue=op_issue=0, slots hold their last value.
//  flush: overrides everything that cycle: no issue, pair_ready=0, next state FULL.
//   Scoreboard keeps counting because older work completes.
//  pair_valid=0: no issue, state held. In HALF, decode must hold the pair stable until pair_ready.
//  stall_cnt: +1 on cycles with pair_valid&&!flush and no issue; saturates at 16'hFFFF.
//  Reset mid-operation: the pending HALF pair is discarded and busy entries are cleared.
// TESTING
//  1. Reset, then pair i0=even(rt=5,lat=2), i1=odd(rt=6,lat=6), no deps
//     -> next cycle ep_issue=1/ep_slot=0, op_issue=1/op_slot=1; pair_ready=1 in the decision cycle.
//  2. Both slots even, independent -> cycle t: i0 issues, pair_ready=0, HALF;
//     t+1: i1 issues to even, pair_ready=1.
//  3. i0 writes r10 lat=6, i1 reads r10 -> i1 split off; held in HALF 6 cycles;
//     issues when busy[10]=0; stall_cnt=6.
//  4. busy[20]=5 from an earlier issue; new i0 writes r20 lat=2 -> WAW blocks
//     until busy[20]<=2 (3 stall cycles).
//  5. In HALF, assert flush -> no issue, pair_ready=0, state FULL; next pair issues normally.
//  6. Assert reset mid-HALF with busy entries set -> all outputs 0 immediately;
//     after release a pair reading those registers issues at once.

Source files
------------

// File: rtl/dual_issue_scheduler_if.sv
// Decode-to-issue bundle for the dual-issue scheduler.
//   master : decode side, presents one instruction pair (i0 older, i1 younger)
//   slave  : scheduler side, returns pair_ready when the whole pair has issued
// Per-slot fields: pipe (0 even / 1 odd), ra/rb/rc sources with src_en {ra,rb,rc},
// rt destination with wr enable, lat result latency (1..MAXLAT).
interface dual_issue_scheduler_if #(
  parameter int AW = 7,
  parameter int LW = 3
);
  logic          pair_valid;
  logic          pair_ready;

  logic          i0_pipe;
  logic [AW-1:0] i0_ra;
  logic [AW-1:0] i0_rb;
  logic [AW-1:0] i0_rc;
  logic [2:0]    i0_src_en;
  logic [AW-1:0] i0_rt;
  logic          i0_wr;
  logic [LW-1:0] i0_lat;

  logic          i1_pipe;
  logic [AW-1:0] i1_ra;
  logic [AW-1:0] i1_rb;
  logic [AW-1:0] i1_rc;
  logic [2:0]    i1_src_en;
  logic [AW-1:0] i1_rt;
  logic          i1_wr;
  logic [LW-1:0] i1_lat;

  modport master (
    output pair_valid,
    output i0_pipe, i0_ra, i0_rb, i0_rc, i0_src_en, i0_rt, i0_wr, i0_lat,
    output i1_pipe, i1_ra, i1_rb, i1_rc, i1_src_en, i1_rt, i1_wr, i1_lat,
    input  pair_ready
  );

  modport slave (
    input  pair_valid,
    input  i0_pipe, i0_ra, i0_rb, i0_rc, i0_src_en, i0_rt, i0_wr, i0_lat,
    input  i1_pipe, i1_ra, i1_rb, i1_rc, i1_src_en, i1_rt, i1_wr, i1_lat,
    output pair_ready
  );
endinterface

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: steers a decoded instruction pair to the even/odd pipes,
// tracks per-register busy countdowns, blocks RAW/WAW hazards, splits pairs that
// cannot co-issue, and drops pending work on flush.
// Ports:
//   clock, reset      core clock (rising edge), asynchronous active-high reset
//   dec (slave)       pair handshake and per-slot instruction fields
//   flush             taken branch: kill unissued work this cycle
//   ep_issue/ep_slot  registered even-pipe issue strobe and source slot
//   op_issue/op_slot  registered odd-pipe issue strobe and source slot
//   stall_cnt         saturating count of valid, non-flush cycles with no issue
//
// state | meaning
// FULL  | neither slot of the presented pair has issued
// HALF  | i0 issued, i1 still pending
module dual_issue_scheduler #(
  parameter int NREG   = 128,
  parameter int MAXLAT = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  dual_issue_scheduler_if.slave  dec,
  input  logic                   flush,
  output logic                   ep_issue,
  output logic                   ep_slot,
  output logic                   op_issue,
  output logic                   op_slot,
  output logic [15:0]            stall_cnt
);
  localparam int AW = $clog2(NREG);
  localparam int LW = $clog2(MAXLAT + 1);

  typedef enum logic {FULL = 1'b0, HALF = 1'b1} state_t;

  state_t        state, next_state;
  logic [LW-1:0] busy [NREG];

  logic raw0, waw0, raw1, waw1;
  logic haz0, haz1;
  logic dep, same_rt, co_ok;
  logic iss0, iss1, ready;

  // busy[r] != 0 means r is not yet forwardable.
  assign raw0 = (dec.i0_src_en[2] && (busy[dec.i0_ra] != '0)) ||
                (dec.i0_src_en[1] && (busy[dec.i0_rb] != '0)) ||
                (dec.i0_src_en[0] && (busy[dec.i0_rc] != '0));
  assign raw1 = (dec.i1_src_en[2] && (busy[dec.i1_ra] != '0)) ||
                (dec.i1_src_en[1] && (busy[dec.i1_rb] != '0)) ||
                (dec.i1_src_en[0] && (busy[dec.i1_rc] != '0));
  // A newer writer must not complete before an older one to the same register.
  assign waw0 = dec.i0_wr && (busy[dec.i0_rt] > dec.i0_lat);
  assign waw1 = dec.i1_wr && (busy[dec.i1_rt] > dec.i1_lat);
  assign haz0 = raw0 || waw0;
  assign haz1 = raw1 || waw1;

  // Intra-pair dependencies the scoreboard cannot see yet.
  assign dep = dec.i0_wr &&
               ((dec.i1_src_en[2] && (dec.i1_ra == dec.i0_rt)) ||
                (dec.i1_src_en[1] && (dec.i1_rb == dec.i0_rt)) ||
                (dec.i1_src_en[0] && (dec.i1_rc == dec.i0_rt)));
  assign same_rt = dec.i0_wr && dec.i1_wr && (dec.i0_rt == dec.i1_rt);
  assign co_ok   = (dec.i1_pipe != dec.i0_pipe) && !haz1 && !dep && !same_rt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FULL;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    iss0       = 1'b0;
    iss1       = 1'b0;
    ready      = 1'b0;
    if (dec.pair_valid && !flush) begin
      case (state)
        FULL: begin
          if (!haz0) begin
            iss0 = 1'b1;
            if (co_ok) begin
              iss1  = 1'b1;
              ready = 1'b1;
            end else begin
              next_state = HALF;
            end
          end
        end
        HALF: begin
          // Nothing else issues in HALF, so i1's pipe is always free.
          if (!haz1) begin
            iss1       = 1'b1;
            ready      = 1'b1;
            next_state = FULL;
          end
        end
        default: next_state = FULL;
      endcase
    end
    if (flush) next_state = FULL;
  end

  assign dec.pair_ready = ready && !reset;

  // Older work keeps completing through a flush, so entries always count down.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) busy[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (iss0 && dec.i0_wr && (dec.i0_rt == AW'(r)))
          busy[r] <= dec.i0_lat;
        else if (iss1 && dec.i1_wr && (dec.i1_rt == AW'(r)))
          busy[r] <= dec.i1_lat;
        else if (busy[r] != '0)
          busy[r] <= busy[r] - LW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ep_issue <= 1'b0;
      ep_slot  <= 1'b0;
      op_issue <= 1'b0;
      op_slot  <= 1'b0;
    end else begin
      ep_issue <= (iss0 && !dec.i0_pipe) || (iss1 && !dec.i1_pipe);
      op_issue <= (iss0 &&  dec.i0_pipe) || (iss1 &&  dec.i1_pipe);
      // Co-issued slots always target different pipes, so at most one
      // assignment per pipe fires.
      if (iss0 && !dec.i0_pipe)      ep_slot <= 1'b0;
      else if (iss1 && !dec.i1_pipe) ep_slot <= 1'b1;
      if (iss0 && dec.i0_pipe)       op_slot <= 1'b0;
      else if (iss1 && dec.i1_pipe)  op_slot <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (dec.pair_valid && !flush && !iss0 && !iss1 && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
endmodule
